// File: rtl/sync_fifo_fwft_if.sv
// Valid/ready streaming bundle for the FWFT FIFO: producer side, consumer side,
// and the status and control lines the FIFO exposes.
interface sync_fifo_fwft_if #(
  parameter int width = 8,
  parameter int depth = 4
);
  logic             flush;
  logic [width-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [width-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [depth:0]   count;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;

  // master drives traffic into and pulls data out of the FIFO
  modport master (
    output flush, din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, count, almost_full, almost_empty, overflow
  );

  modport slave (
    input  flush, din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, count, almost_full, almost_empty, overflow
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO of 2^depth entries with occupancy
// count, almost-full/almost-empty thresholds, synchronous flush and sticky overflow.
module sync_fifo_fwft #(
  parameter int width              = 8,
  parameter int depth              = 4,
  parameter int almost_full_level  = (1 << depth) - 2,
  parameter int almost_empty_level = 1
) (
  input logic             clock,
  input logic             reset,
  sync_fifo_fwft_if.slave bus
);
  localparam int entries = 1 << depth;
  localparam logic [depth:0] ptr_one  = (depth + 1)'(1);
  localparam logic [depth:0] af_level = (depth + 1)'(almost_full_level);
  localparam logic [depth:0] ae_level = (depth + 1)'(almost_empty_level);

  logic [width-1:0] mem_q [entries];
  logic [depth:0]   wr_ptr_q, wr_ptr_d;
  logic [depth:0]   rd_ptr_q, rd_ptr_d;
  logic [depth:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, wr_en, rd_en;

  // The wrap bit distinguishes full from empty when the low address bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[depth-1:0] == rd_ptr_q[depth-1:0]) &&
                 (wr_ptr_q[depth] != rd_ptr_q[depth]);

  assign wr_en = bus.din_valid && !full && !bus.flush;
  assign rd_en = bus.dout_ready && !empty && !bus.flush;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (bus.din_valid & full);
    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ptr_one;
      if (rd_en) rd_ptr_d = rd_ptr_q + ptr_one;
    end
    count_d = wr_ptr_d - rd_ptr_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q[depth-1:0]] <= bus.din;
  end

  assign bus.dout         = mem_q[rd_ptr_q[depth-1:0]];
  assign bus.dout_valid   = !empty;
  assign bus.din_ready    = !full;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= af_level);
  assign bus.almost_empty = (count_q <= ae_level);
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft: queue scoreboard plus a vector table
// and hand-written sequences for fill/drain, overflow, wrap, flush and async reset.
module tb_sync_fifo_fwft;
  localparam int W = 8;
  localparam int D = 4;
  localparam int CAP = 1 << D;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sync_fifo_fwft_if #(.width(W), .depth(D)) bus ();

  sync_fifo_fwft #(.width(W), .depth(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [W-1:0] sb[$];
  bit m_ovf = 1'b0;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         f;
    int           exp_count;
    logic         exp_dv;
    logic [W-1:0] exp_dout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = sb.size();
    check({tag, " count"},        32'(bus.count),    32'(n));
    check({tag, " din_ready"},    32'(bus.din_ready), 32'(n < CAP));
    check({tag, " dout_valid"},   32'(bus.dout_valid), 32'(n != 0));
    check({tag, " almost_full"},  32'(bus.almost_full), 32'(n >= CAP - 2));
    check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(n <= 1));
    check({tag, " overflow"},     32'(bus.overflow), 32'(m_ovf));
    if (n > 0) check({tag, " dout"}, 32'(bus.dout), 32'(sb[0]));
  endtask

  // Called at posedge+1; drives one cycle of stimulus and checks both before and after the edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bit acc_wr, acc_rd;
    bus.din_valid  = v;
    bus.din        = d;
    bus.dout_ready = r;
    bus.flush      = f;
    #1 check_outputs("pre");
    acc_rd = r && (sb.size() > 0);
    acc_wr = v && (sb.size() < CAP);
    if (f) begin
      sb.delete();
      m_ovf = 1'b0;
    end else begin
      if (v && !acc_wr) m_ovf = 1'b1;
      if (acc_rd) void'(sb.pop_front());
      if (acc_wr) sb.push_back(d);
    end
    @(posedge clock);
    #1 check_outputs("post");
  endtask

  task automatic idle_inputs();
    bus.din_valid  = 1'b0;
    bus.din        = '0;
    bus.dout_ready = 1'b0;
    bus.flush      = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1, 1'b1, 8'hA1};
    vecs[1] = '{1'b1, 8'hA2, 1'b0, 1'b0, 2, 1'b1, 8'hA1};
    vecs[2] = '{1'b1, 8'hA3, 1'b1, 1'b0, 2, 1'b1, 8'hA2};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'hA3};
    vecs[4] = '{1'b1, 8'hA4, 1'b0, 1'b1, 0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 8'hB0, 1'b1, 1'b0, 1, 1'b1, 8'hB0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};

    idle_inputs();
    reset = 1'b1;
    #3 check_outputs("reset");
    @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock);
    #1 check_outputs("after_reset");

    // Vector table: short mixed traffic including flush and read-on-empty.
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f);
      check($sformatf("vec%0d count", i), 32'(bus.count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d dout_valid", i), 32'(bus.dout_valid), 32'(vecs[i].exp_dv));
      if (vecs[i].exp_dv) check($sformatf("vec%0d dout", i), 32'(bus.dout), 32'(vecs[i].exp_dout));
    end

    // Fill and drain.
    for (int i = 0; i < CAP; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
    check("fill count", 32'(bus.count), 32'(CAP));
    check("fill din_ready", 32'(bus.din_ready), 32'(0));
    for (int i = 0; i < CAP; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain dout_valid", 32'(bus.dout_valid), 32'(0));

    // Overflow while full, then flush.
    for (int i = 0; i < CAP; i++) cycle(1'b1, W'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf flag", 32'(bus.overflow), 32'(1));
    check("ovf count", 32'(bus.count), 32'(CAP));
    check("ovf head", 32'(bus.dout), 32'(8'h10));
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("flush overflow", 32'(bus.overflow), 32'(0));
    check("flush count", 32'(bus.count), 32'(0));
    check("flush dout_valid", 32'(bus.dout_valid), 32'(0));

    // Simultaneous read/write at half occupancy across several pointer wraps.
    for (int i = 0; i < 8; i++) cycle(1'b1, W'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, W'($urandom_range(0, 255)), 1'b1, 1'b0);
      check("half count", 32'(bus.count), 32'(8));
    end
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Empty boundary: no bypass in the write cycle.
    bus.din_valid = 1'b1; bus.din = 8'h55; bus.dout_ready = 1'b1; bus.flush = 1'b0;
    #1 check("empty wr cycle dout_valid", 32'(bus.dout_valid), 32'(0));
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    check("empty next dout", 32'(bus.dout), 32'(8'h55));
    check("empty next dout_valid", 32'(bus.dout_valid), 32'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("empty again dout_valid", 32'(bus.dout_valid), 32'(0));
    check("empty again almost_empty", 32'(bus.almost_empty), 32'(1));

    // Flush against concurrent write and read.
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(8'h60 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b1);
    check("flush traffic count", 32'(bus.count), 32'(0));
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("flush traffic discarded", 32'(bus.dout_valid), 32'(0));

    // Asynchronous reset with 5 entries stored and overflow set.
    for (int i = 0; i < CAP; i++) cycle(1'b1, W'(8'h80 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < CAP - 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("pre reset count", 32'(bus.count), 32'(5));
    idle_inputs();
    #2 reset = 1'b1;
    sb.delete();
    m_ovf = 1'b0;
    #1 check_outputs("async_reset");
    @(posedge clock);
    #2 check_outputs("reset_held");
    reset = 1'b0;
    @(posedge clock);
    #1 check_outputs("reset_released");
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    check("post reset dout", 32'(bus.dout), 32'(8'h3C));
    check("post reset dout_valid", 32'(bus.dout_valid), 32'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Parametrised single-clock first-word-fall-through FIFO, the next generation of the team's synchronous FIFO. Capacity is exactly 2^depth entries, with no wasted slots. It adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush and a sticky overflow flag. It sits between streaming blocks that use valid/ready handshakes in one clock domain.

## Interface
- width, 8, data bits per entry (≥1)
- depth, 4, address bits; capacity = 2^depth entries (≥1)
- almost_full_level, 2^depth − 2, almost_full asserts when count ≥ this value (1..2^depth)
- almost_empty_level, 1, almost_empty asserts when count ≤ this value (0..2^depth−1)

Ports:
- clock  in  1  sole clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous; empties the FIFO on the next edge
- din  in  width  write data
- din_valid  in  1  write request
- din_ready  out  1  FIFO can accept; equals !full
- dout  out  width  head-of-queue data, valid while dout_valid
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer takes head this cycle
- count  out  depth+1  current occupancy, 0..2^depth
- almost_full  out  1  count ≥ almost_full_level
- almost_empty  out  1  count ≤ almost_empty_level
- overflow  out  1  sticky: a write was attempted while full

## Operation
- Storage: register array of 2^depth × width. Read and write pointers are depth+1 bits wide; the MSB is the wrap bit.
- Empty when pointers are equal in all bits. Full when the low depth bits are equal and the MSBs differ.
- count = wr_ptr − rd_ptr, modulo 2^(depth+1). It is held in a register and updated with the pointers.
- Write accepted iff din_valid && din_ready. On acceptance: mem[wr_ptr low bits] ← din, then wr_ptr increments.
- Read accepted iff dout_ready && dout_valid. On acceptance: rd_ptr increments.
- dout = mem[rd_ptr low bits], combinational from registered state (fall-through). dout is don't-care while dout_valid = 0.
- Simultaneous accepted read and write: count is unchanged, and both pointers advance.
- When full, din_ready = 0 even if a read happens the same cycle; there is no write-through-on-full.
- When empty, a write is not bypassed to dout in the same cycle.
- din_valid && !din_ready sets overflow. The data is dropped and no other state changes.
- flush = 1 clears both pointers, count and overflow on the next edge. Flush overrides any write or read in that cycle. Memory contents are not cleared.
- Pointer wrap: the low bits roll from 2^depth−1 to 0 and the MSB toggles. There is no special case.

## Timing
- Reset values (asynchronous, held while reset = 1):
  - pointers = 0, count = 0, overflow = 0
  - din_ready = 1, dout_valid = 0
  - almost_empty = 1 (since 0 ≤ almost_empty_level), almost_full = 0
- Write-to-read latency is 1 cycle: a word accepted at edge N is on dout with dout_valid = 1 after edge N.
- Read: on the edge where dout_ready && dout_valid, the next word (if any) appears on dout after that edge.
- din_ready, dout_valid, count, almost_full and almost_empty depend only on registered state, never on same-cycle inputs.
- Throughput is one write and one read per cycle sustained in steady state.
- Reset released mid-stream: the FIFO resumes empty; the first write after release is readable one cycle later.

## Test plan
- **Fill and drain.** Depth 4 (16 entries). Write 0x00..0x0F back-to-back with dout_ready = 0. Require:
  - din_ready drops after the 16th accept; count = 16; almost_full from count 14.
  - Then hold dout_ready = 1: the outputs are 0x00..0x0F in order, one per cycle, and dout_valid drops after the last.
- **Overflow.** When full, drive din_valid = 1 with din = 0xAA for 3 cycles. Require:
  - overflow = 1 and count stays 16; 0xAA never appears on dout.
  - flush clears overflow and count to 0, and dout_valid goes to 0 the next cycle.
- **Simultaneous read/write at half occupancy.** With 8 entries, run 100 cycles of din_valid = dout_ready = 1. Require:
  - count stays 8 throughout.
  - The output sequence equals the input delayed by 8 accepted words, crossing the pointer wrap several times.
- **Empty boundary.** Write 0x55 in one cycle while the FIFO is empty and dout_ready = 1. Require:
  - dout_valid = 0 in the write cycle; dout = 0x55 with dout_valid = 1 the next cycle.
  - After that read, the FIFO is empty again with almost_empty = 1.
- **Flush versus concurrent traffic.** Assert flush together with din_valid and dout_ready. Require count = 0 next cycle and the written word discarded.
- **Asynchronous reset.** Assert reset between clock edges with 5 entries stored. Require:
  - All outputs reach reset values immediately, without waiting for an edge.
  - After release, normal operation resumes from empty.
